// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte/block types, round FSM states, inverse S-box and inverse-cipher helpers
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:15] block_t;

  typedef enum logic [1:0] {IDLE, LOOK, WAIT, DONE} state_e;

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte i sits at row i%4, column i/4; row r rotates right by r.
  function automatic block_t inv_shift_rows(input block_t b);
    block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c + r] = b[4*((c - r + 4) % 4) + r];
    return o;
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Undo the affine map, then invert in GF(2^8) as x^254.
  function automatic byte_t inv_sbox_calc(input byte_t s);
    byte_t a, p, r;
    a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox_lane.sv
// rtl/inv_sbox_lane.sv - one registered inverse S-box lookup, table (ROM) or computed (logic)
module inv_sbox_lane
  import aes_pkg::*;
#(
  parameter int SELECT_SUBBYTE = 1
) (
  input  logic       clk,
  input  logic       en,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  generate
    if (SELECT_SUBBYTE == 1) begin : g_rom
      always_ff @(posedge clk) begin
        if (en) data <= INV_SBOX[addr];
      end
    end else begin : g_logic
      always_ff @(posedge clk) begin
        if (en) data <= inv_sbox_calc(addr);
      end
    end
  endgenerate

endmodule

// File: rtl/inv_first_round.sv
// rtl/inv_first_round.sv - AES inverse-cipher first round (AddRoundKey, InvShiftRows, InvSubBytes)
// INV_FIRST_ROUND_PARALLEL_EN selects 16 parallel S-box lanes; otherwise 4 lanes walk the columns.
module inv_first_round
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH      = 128,
  parameter int DATA_WIDTH     = 128,
  parameter int ROM_WIDTH      = 20,
  parameter int SELECT_SUBBYTE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  keyLen,
  input  logic [DATA_WIDTH-1:0] prev_key,
  input  logic [DATA_WIDTH-1:0] key_in,
  input  logic [DATA_WIDTH-1:0] state_in,
  input  logic                  round_valid_in,
  output logic                  round_ready_out,
  output logic [DATA_WIDTH-1:0] state_out,
  output logic                  round_valid_out,
  input  logic                  round_ready_in
);

  generate
    if ((KEY_WIDTH != 128 && KEY_WIDTH != 256) || DATA_WIDTH != 128 || ROM_WIDTH < 8) begin : g_bad_cfg
      $error("inv_first_round: unsupported KEY_WIDTH/DATA_WIDTH/ROM_WIDTH");
    end
  endgenerate

`ifdef INV_FIRST_ROUND_PARALLEL_EN
  localparam int LANES = 16;
`else
  localparam int LANES = 4;
`endif

  state_e              state, state_nx;
  logic [1:0]          cnt, cnt_nx;
  logic                accept, look;
  block_t              t, sh, fin, out_q;
  byte_t [0:LANES-1]   lane_q;

  assign round_ready_out = !rst && ((state == IDLE) || (state == DONE && round_ready_in));
  assign round_valid_out = (state == DONE);
  assign accept          = round_valid_in && round_ready_out;
  assign look            = (state == LOOK);
  assign sh              = inv_shift_rows(t);
  assign state_out       = out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nx = LOOK;
        cnt_nx   = 2'd0;
      end
      LOOK: begin
        cnt_nx = cnt + 2'd1;
`ifdef INV_FIRST_ROUND_PARALLEL_EN
        state_nx = WAIT;
`else
        if (cnt == 2'd3) state_nx = WAIT;
`endif
      end
      WAIT: state_nx = DONE;
      DONE: begin
        if (accept) begin
          state_nx = LOOK;
          cnt_nx   = 2'd0;
        end else if (round_ready_in) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) t <= state_in ^ (keyLen ? prev_key : key_in);
  end

  // state_out moves only on entry to DONE, so a held output never tears.
  always_ff @(posedge clk) begin
    if (rst)                out_q <= '0;
    else if (state == WAIT) out_q <= fin;
  end

`ifdef INV_FIRST_ROUND_PARALLEL_EN
  for (genvar i = 0; i < 16; i++) begin : g_lane
    inv_sbox_lane #(.SELECT_SUBBYTE(SELECT_SUBBYTE)) u_lane (
      .clk  (clk),
      .en   (look),
      .addr (sh[i]),
      .data (lane_q[i])
    );
  end

  assign fin = lane_q;
`else
  logic [1:0]   wcol;
  byte_t [0:11] res_buf;

  assign wcol = cnt - 2'd1;

  for (genvar r = 0; r < 4; r++) begin : g_lane
    inv_sbox_lane #(.SELECT_SUBBYTE(SELECT_SUBBYTE)) u_lane (
      .clk  (clk),
      .en   (look),
      .addr (sh[{cnt, 2'(r)}]),
      .data (lane_q[r])
    );
  end

  // The lane output lags one column behind cnt; column 3 goes straight to out_q.
  always_ff @(posedge clk) begin
    if (look && cnt != 2'd0) begin
      for (int r = 0; r < 4; r++) res_buf[{wcol, 2'(r)}] <= lane_q[r];
    end
  end

  assign fin = {res_buf, lane_q};
`endif

endmodule

// File: tb/tb_inv_first_round.sv
// tb/tb_inv_first_round.sv - scoreboard bench for inv_first_round against a table-free AES reference
module tb_inv_first_round;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         keyLen = 1'b0;
  logic [127:0] prev_key = '0, key_in = '0, state_in = '0;
  logic         round_valid_in = 1'b0, round_ready_in = 1'b1;
  logic [127:0] state_out;
  logic         round_ready_out, round_valid_out;

  always #5 clk = ~clk;

  inv_first_round dut (
    .clk             (clk),
    .rst             (rst),
    .keyLen          (keyLen),
    .prev_key        (prev_key),
    .key_in          (key_in),
    .state_in        (state_in),
    .round_valid_in  (round_valid_in),
    .round_ready_out (round_ready_out),
    .state_out       (state_out),
    .round_valid_out (round_valid_out),
    .round_ready_in  (round_ready_in)
  );

`ifdef INV_FIRST_ROUND_PARALLEL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 5;
`endif

  typedef struct {
    logic [127:0] data;
    int           acc_cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       bp_rand = 1'b0;
  logic [7:0] inv_tab [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from its definition (brute-force inverse + affine), then inverted.
  task automatic build_tab();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 8'h00;
      logic [7:0] s;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k);
    logic [7:0]   m [4][4];
    logic [127:0] x = s ^ k;
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) m[i % 4][i / 4] = x[127 - 8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = inv_tab[m[r][(c - r + 4) % 4]];
    return o;
  endfunction

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic [127:0] pk,
                      input logic kl, input logic [127:0] e);
    logic acc = 1'b0;
    exp_t it;
    state_in = s; key_in = k; prev_key = pk; keyLen = kl; round_valid_in = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = round_ready_out;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      it.data = e;
      it.acc_cyc = cyc;
      sb.push_back(it);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    round_valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_rand) round_ready_in = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops and compares on every consumed output; also polices holds and latency.
  initial begin
    logic         prev_valid = 1'b0;
    logic         prev_hold = 1'b0;
    logic [127:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready_out_during_rst", round_ready_out, 1'b0);
        prev_valid = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", round_valid_out, 1'b1);
          chk("hold_data", state_out, prev_data);
        end
        if (round_valid_out && !prev_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got %h expected no valid output", state_out);
          end else begin
            chk("latency", 128'(cyc - sb[0].acc_cyc), 128'(LAT));
          end
        end
        if (round_valid_out && !round_ready_in) chk("ready_out_backpressure", round_ready_out, 1'b0);
        if (round_valid_out && round_ready_in && sb.size() > 0) begin
          chk("data", state_out, sb[0].data);
          void'(sb.pop_front());
        end
        prev_valid = round_valid_out;
        prev_hold  = round_valid_out && !round_ready_in;
        prev_data  = state_out;
      end
    end
  end

  initial begin
    logic [127:0] s, k, pk;
    logic         kl, seen;
    build_tab();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", round_valid_out, 1'b0);
    chk("reset_state_out", state_out, 128'h0);
    chk("reset_ready", round_ready_out, 1'b1);
    @(posedge clk);
    #1;

    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
         rnd128(), 1'b0, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
    idle(8);
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h0,
         128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
    idle(8);
    send(128'h0, 128'h0, rnd128(), 1'b0, {16{8'h52}});
    idle(8);

    round_ready_in = 1'b0;
    s = rnd128(); k = rnd128();
    send(s, k, rnd128(), 1'b0, model(s, k));
    round_valid_in = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = round_valid_out;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid expected valid within 50 cycles");
    end
    repeat (10) @(posedge clk);
    #1 round_ready_in = 1'b1;
    idle(3);

    s = rnd128(); k = rnd128();
    send(s, k, rnd128(), 1'b0, model(s, k));
    s = rnd128(); pk = rnd128();
    send(s, rnd128(), pk, 1'b1, model(s, pk));
    idle(8);

    s = rnd128(); k = rnd128();
    send(s, k, rnd128(), 1'b0, model(s, k));
    rst = 1'b1;
    sb.delete();
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("midop_rst_valid", round_valid_out, 1'b0);
    chk("midop_rst_state_out", state_out, 128'h0);
    chk("midop_rst_ready", round_ready_out, 1'b1);
    idle(10);

    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s = rnd128(); k = rnd128(); pk = rnd128(); kl = 1'($urandom);
      send(s, k, pk, kl, model(s, kl ? pk : k));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
    end
    round_valid_in = 1'b0;
    bp_rand = 1'b0;
    @(posedge clk);
    #1 round_ready_in = 1'b1;

    for (int n = 0; n < 200 && sb.size() > 0; n++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
